mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16; cycles a grant may wait for ACCESS before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 SHALL have parameter BAD, default 32'hBAD1BAD1; load value returned on abort.
REQ-003 SHALL have ports, clock and reset first:
- CLK in 1: clock, posedge.
- nRST in 1: reset, asynchronous, active-low.
- iREN in 1: instruction read request.
- iaddr in 32: instruction address.
- iwait out 1: instruction port stall.
- iload out 32: instruction read data.
- dREN in 1: data read request.
- dWEN in 1: data write request.
- daddr in 32: data address.
- dstore in 32: data write value.
- dwait out 1: data port stall.
- dload out 32: data read data.
- ramREN out 1: RAM read enable.
- ramWEN out 1: RAM write enable.
- ramaddr out 32: RAM address.
- ramstore out 32: RAM write data.
- ramload in 32: RAM read data.
- ramstate in 2: ramstate_t {FREE, BUSY, ACCESS, ERROR}.
- err out 1: sticky timeout flag.

Function
REQ-004 SHALL implement registered FSM arbstate_t {IDLE, DGNT, IGNT}.
REQ-005 In IDLE: ramREN=ramWEN=0; ramaddr=0; ramstore=0; iwait=iREN; dwait=dREN|dWEN.
REQ-006 IDLE transitions: dREN|dWEN -> DGNT; else iREN -> IGNT; else stay. Data wins simultaneous requests.
REQ-007 In DGNT: ramaddr=daddr; ramstore=dstore; ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both set). All are combinational from the d port.
REQ-008 In IGNT: ramaddr=iaddr; ramREN=iREN; ramWEN=0; ramstore=0.
REQ-009 Granted port wait SHALL be 0 exactly in cycles where ramstate==ACCESS, else 1; the non-granted port's wait SHALL be 1 while it requests.
REQ-010 dload/iload SHALL equal ramload when their port is granted and ramstate==ACCESS, else 0.
REQ-011 On ACCESS completion the next state SHALL be: the other port if it requests (round-robin), else the same port if it still requests, else IDLE.
REQ-012 If the granted port drops its request before ACCESS, the FSM SHALL return to IDLE next cycle with no completion.
REQ-013 ramstate BUSY or ERROR SHALL keep the grant and hold wait=1.
REQ-014 Port addresses and data SHALL pass through unmodified (32-bit, no truncation). RAM latency is handled purely by waiting for ACCESS, so the block is correct for any LAT.

Reset
REQ-015 On nRST low the state SHALL become IDLE asynchronously. err and the watchdog count SHALL clear to 0.
REQ-016 During reset all outputs SHALL follow IDLE values: ram enables 0, loads 0, waits equal to the request inputs.
REQ-017 Reset asserted mid-grant SHALL drop ram enables in the same cycle. No transaction SHALL resume after reset.

Configuration
REQ-018 Macro MEM_ARB_TIMEOUT_EN defined: a counter clears on grant entry or ACCESS and increments each granted cycle without ACCESS.
REQ-019 When that count reaches TIMEOUT-1: granted wait=0, load=BAD, err set (sticky until reset), and next state follows REQ-011.
REQ-020 Macro undefined: no counter; err tied 0; grants wait indefinitely.

Structure
REQ-021 arbstate_t and the BAD constant SHALL live in cpu_types_pkg. ramstate_t and word_t SHALL be reused from that package.
REQ-022 The watchdog SHALL be sub-module mem_watchdog (CLK, nRST, clear, tick, expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-023 Using a ram model with LAT=2, the bench SHALL cover these directed scenarios:
- iREN, iaddr=0x40, ram holds 0x24020001 -> iwait high 2 cycles, then iload=0x24020001 with iwait=0 for one cycle.
- dWEN, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x100; dwait drops on ACCESS; a later read of 0x100 returns 0xDEADBEEF.
- iREN and dREN asserted in the same cycle -> data served first; the instruction is granted immediately after with no IDLE bubble.
- Both ports requesting continuously -> grants alternate D, I, D, I; neither port is starved.
- dREN dropped one cycle after grant -> IDLE next cycle, ramREN=0, no dload pulse.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=4, ram held BUSY -> dwait=0 on the 4th granted cycle, dload=0xBAD1BAD1, err=1 until nRST.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, arbiter grant state and the abort word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, DGNT, IGNT} arbstate_t;

  localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_watchdog.sv
// Grant watchdog: counts granted cycles without ACCESS and flags the cycle that hits TIMEOUT-1.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  assign expired = tick && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single RAM; data wins ties, round-robin on completion.
// Optional grant watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter word_t       BAD     = BAD_WORD
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  arbstate_t state, next_state;
  logic      dreq, access, granted, expired, done;

  assign dreq    = dREN | dWEN;
  assign access  = (ramstate == ACCESS);
  assign granted = (state != IDLE);
  assign done    = granted & (access | expired);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RAM-facing side depends only on the grant and the port inputs, never on ramstate.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    iwait      = iREN;
    dwait      = dreq;
    iload      = '0;
    dload      = '0;
    case (state)
      IDLE: begin
        if (dreq) begin
          next_state = DGNT;
        end else if (iREN) begin
          next_state = IGNT;
        end
      end
      DGNT: begin
        dwait = ~done;
        if (access) begin
          dload = ramload;
        end else if (expired) begin
          dload = BAD;
        end
        if (done) begin
          next_state = iREN ? IGNT : (dreq ? DGNT : IDLE);
        end else if (!dreq) begin
          next_state = IDLE;
        end
      end
      IGNT: begin
        iwait = ~done;
        if (access) begin
          iload = ramload;
        end else if (expired) begin
          iload = BAD;
        end
        if (done) begin
          next_state = dreq ? DGNT : (iREN ? IGNT : IDLE);
        end else if (!iREN) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_clear, wd_tick, err_q;

  // Restart the count whenever a grant begins, completes or is abandoned.
  assign wd_tick  = granted & ~access;
  assign wd_clear = ~granted | done | (next_state != state);

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (wd_clear),
    .tick    (wd_tick),
    .expired (expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err_q <= 1'b0;
    end else if (expired) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
  assign err            = 1'b0;
`endif

endmodule
